// File: rtl/fib_stream_fifo.sv
// Buffers Fibonacci terms from the generator in a first-word-fall-through FIFO.
// Also counts the accepted terms and flags a term smaller than its predecessor.
module fib_stream_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           terms,
  output logic                       wrap_flag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [CNT_W-1:0]  r_terms;
  logic [DATA_W-1:0] r_prev;
  logic              r_seen;
  logic              r_wrap;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake flags come only from the registered level, so out_ready
  // never reaches in_ready combinationally.
  always_comb begin
    w_full  = (r_level == FULL_LVL);
    w_empty = (r_level == '0);
    w_push  = in_valid & ~w_full & ~clr;
    w_pop   = ~w_empty & out_ready & ~clr;
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign terms     = r_terms;
  assign wrap_flag = r_wrap;

  // Storage holds no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push && rst_n) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_terms <= '0;
      r_prev  <= '0;
      r_seen  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_push) begin
      if (r_terms != '1) r_terms <= r_terms + 1'b1;
      r_prev <= in_data;
      r_seen <= 1'b1;
      if (r_seen && (in_data < r_prev)) r_wrap <= 1'b1;
    end
  end

endmodule
